// File: rtl/mult_pkg.sv
// Shared constants for the sequential shift-add multiplier: FSM state
// encodings and the default operand width.
package mult_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    localparam int MULT_W_DEFAULT = 8;
endpackage

// File: rtl/mult_sign_adj.sv
// Conditional two's-complement negate: passes value through, or returns
// its negation modulo 2^N when neg is set.
module mult_sign_adj #(
    parameter int N = 8
) (
    input  logic [N-1:0] value,
    input  logic         neg,
    output logic [N-1:0] result
);
    assign result = neg ? (N'(0) - value) : value;
endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier: one partial product per clock,
// signed/unsigned per operation, start/ready/done handshake.
module seq_mult_param
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 ready,
    output logic                 done
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] mcand_q,  mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q,    acc_d;
    logic             neg_q,    neg_d;
    logic [PW-1:0]    product_q, product_d;
    logic             ready_q,  ready_d;
    logic             done_q,   done_d;

    logic             neg_a, neg_b;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [PW-1:0]    result;
    logic [PW-1:0]    addend;

    // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
    assign neg_a = signed_mode & A[WIDTH-1];
    assign neg_b = signed_mode & B[WIDTH-1];

    mult_sign_adj #(.N(WIDTH)) u_mag_a (.value(A),     .neg(neg_a), .result(a_mag));
    mult_sign_adj #(.N(WIDTH)) u_mag_b (.value(B),     .neg(neg_b), .result(b_mag));
    mult_sign_adj #(.N(PW))    u_res   (.value(acc_q), .neg(neg_q), .result(result));

    assign addend = {{WIDTH{1'b0}}, mcand_q} << cnt_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = neg_a ^ neg_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (mplier_q[0]) acc_d = acc_q + addend;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
            end
            S_FINISH: begin
                product_d = result;
                done_d    = 1'b1;
                ready_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign Product = product_q;
    assign ready   = ready_q;
    assign done    = done_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: 8-bit directed vectors plus a 16-bit
// instance driven with corner and random operands against a reference product.
module tb_seq_mult_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        ready8, done8;
    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        ready16, done16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .A(a8), .B(b8), .Product(p8), .ready(ready8), .done(done8)
    );

    seq_mult_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .A(a16), .B(b16), .Product(p16), .ready(ready16), .done(done16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts one 8-bit op; checks done arrives exactly 9 edges after capture.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic sm, input logic [15:0] exp);
        logic [15:0] prev;
        prev   = p8;
        start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
        step();
        start8 = 1'b0; a8 = 'x; b8 = 'x;
        chk({tag, "_busy"}, {31'd0, ready8}, 32'd0);
        repeat (8) step();
        chk({tag, "_early_done"}, {31'd0, done8}, 32'd0);
        chk({tag, "_hold"}, {16'd0, p8}, {16'd0, prev});
        step();
        chk({tag, "_done"}, {31'd0, done8}, 32'd1);
        chk({tag, "_prod"}, {16'd0, p8}, {16'd0, exp});
        chk({tag, "_ready"}, {31'd0, ready8}, 32'd1);
        step();
        chk({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        logic [31:0] ea, eb;
        ea = sm ? {{16{a[15]}}, a} : {16'd0, a};
        eb = sm ? {{16{b[15]}}, b} : {16'd0, b};
        return ea * eb;
    endfunction

    // Starts one 16-bit op; result and done must appear exactly 17 edges after capture.
    task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sm);
        int early;
        early   = 0;
        start16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
        step();
        start16 = 1'b0; a16 = 'x; b16 = 'x;
        for (int k = 0; k < 16; k++) begin
            step();
            if (done16) early++;
        end
        chk({tag, "_early_done"}, early, 32'd0);
        step();
        chk({tag, "_done"}, {31'd0, done16}, 32'd1);
        chk({tag, "_prod"}, p16, ref16(a, b, sm));
        step();
    endtask

    initial begin
        int dones;
        logic [15:0] ra, rb;
        logic        rs;
        rst = 1'b1;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
        step();
        chk("rst_prod", {16'd0, p8}, 32'd0);
        chk("rst_ready", {31'd0, ready8}, 32'd1);
        chk("rst_done", {31'd0, done8}, 32'd0);
        rst = 1'b0;
        repeat (20) step();
        chk("idle_prod", {16'd0, p8}, 32'd0);
        chk("idle_ready", {31'd0, ready8}, 32'd1);
        chk("idle_done", {31'd0, done8}, 32'd0);

        run8("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run8("u_fd_05", 8'hFD, 8'h05, 1'b0, 16'h04F1);
        run8("s_fd_05", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        run8("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
        run8("s_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080);

        // Busy-ignore: extra starts at +2 and +5, then back-to-back in the done cycle.
        sm8 = 1'b0; start8 = 1'b1; a8 = 8'd3; b8 = 8'd4;
        step();
        start8 = 1'b0;
        dones = 0;
        step(); dones += done8;
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
        step(); dones += done8;
        start8 = 1'b0;
        step(); dones += done8;
        step(); dones += done8;
        start8 = 1'b1;
        step(); dones += done8;
        start8 = 1'b0;
        repeat (3) begin step(); dones += done8; end
        chk("busy_no_early_done", dones, 32'd0);
        step();
        chk("busy_done", {31'd0, done8}, 32'd1);
        chk("busy_prod", {16'd0, p8}, 32'h000C);
        start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
        step();
        start8 = 1'b0;
        chk("b2b_accepted", {31'd0, ready8}, 32'd0);
        chk("b2b_hold", {16'd0, p8}, 32'h000C);
        chk("b2b_single_done", {31'd0, done8}, 32'd0);
        repeat (8) step();
        chk("b2b_early_done", {31'd0, done8}, 32'd0);
        step();
        chk("b2b_done", {31'd0, done8}, 32'd1);
        chk("b2b_prod", {16'd0, p8}, 32'h0004);
        step();

        // Reset mid-operation: asserted at the fourth edge after capture.
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
        step();
        start8 = 1'b0;
        repeat (3) step();
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_prod", {16'd0, p8}, 32'd0);
        chk("midrst_ready", {31'd0, ready8}, 32'd1);
        chk("midrst_done", {31'd0, done8}, 32'd0);
        step();
        rst = 1'b0;
        dones = 0;
        repeat (12) begin step(); dones += done8; end
        chk("midrst_no_done", dones, 32'd0);
        run8("after_rst", 8'd6, 8'd7, 1'b0, 16'h002A);

        run16("w16_u_ffff", 16'hFFFF, 16'hFFFF, 1'b0);
        chk("w16_u_ffff_const", p16, 32'hFFFE0001);
        run16("w16_s_8000", 16'h8000, 16'hFFFF, 1'b1);
        chk("w16_s_8000_const", p16, 32'h00008000);
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            run16("w16_rand", ra, rb, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
